// File: rtl/dcache_mem_pkg.sv
// Constants, state encoding and address helpers shared by the dcache
// controller and its line-memory responder.
package dcache_mem_pkg;

  localparam int LINE_W      = 256;
  localparam int OFFSET_BITS = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_e;

  // Line number of a byte address, wrapped to a power-of-two line count.
  function automatic logic [31:0] line_index(input logic [63:0] addr, input int depth);
    logic [63:0] line;
    line = addr >> OFFSET_BITS;
    return line[31:0] & 32'(depth - 1);
  endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Line storage: synchronous write port, asynchronous read port.
// Contents are deliberately not reset.
module dcache_line_array #(
  parameter  int LINE_W = 256,
  parameter  int DEPTH  = 512,
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  windex,
  input  logic [LINE_W-1:0] wdata,
  input  logic [IDX_W-1:0]  rindex,
  output logic [LINE_W-1:0] rdata
);

  logic [LINE_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[windex] <= wdata;
  end

  assign rdata = mem[rindex];

endmodule

// File: rtl/dcache_line_memory.sv
// Memory-side responder for the L1 dcache: serves whole-line fills and
// write-backs with a fixed latency, one request at a time.
module dcache_line_memory
  import dcache_mem_pkg::*;
#(
  parameter int LINE_W  = dcache_mem_pkg::LINE_W,
  parameter int DEPTH   = 512,
  parameter int LATENCY = 10,
  parameter int ADDR_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              write_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LINE_W-1:0] data_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o,
  output logic              busy_o
);

  localparam int         IDX_W    = $clog2(DEPTH);
  localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

  if (LATENCY < 1 || LATENCY > 255) begin : g_bad_latency
    $error("dcache_line_memory: LATENCY must lie in 1..255");
  end

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              accept;
  logic [IDX_W-1:0]  addr_index;
  logic [IDX_W-1:0]  req_index;
  logic              req_write;
  logic [LINE_W-1:0] req_data;
  logic [LINE_W-1:0] rdata;
  logic              we;

  assign addr_index = IDX_W'(line_index(64'(addr_i), DEPTH));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_i) begin
          accept  = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 8'd0) state_d = ACK;
        else               cnt_d   = cnt_q - 8'd1;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      req_index <= '0;
      req_write <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        req_index <= addr_index;
        req_write <= write_i;
      end
    end
  end

  // Line payload needs no reset: it is only consumed after a capture.
  always_ff @(posedge clk_i) begin
    if (accept) req_data <= data_i;
  end

  // Commit happens on the edge leaving ACK; an async reset in ACK kills it.
  assign we = (state_q == ACK) && req_write;

  dcache_line_array #(
    .LINE_W (LINE_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk    (clk_i),
    .we     (we),
    .windex (req_index),
    .wdata  (req_data),
    .rindex (req_index),
    .rdata  (rdata)
  );

  assign ack_o  = (state_q == ACK);
  assign busy_o = (state_q != IDLE);
  assign data_o = (ack_o && !req_write) ? rdata : '0;

endmodule

// File: tb/tb_dcache_line_memory.sv
// Scoreboard bench for dcache_line_memory: a LATENCY=10 instance with directed
// and random traffic, plus a LATENCY=1 instance for back-to-back timing.
module tb_dcache_line_memory;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         en_a, wr_a, ack_a, busy_a;
  logic [31:0]  addr_a;
  logic [255:0] din_a, dout_a;
  logic         en_b, wr_b, ack_b, busy_b;
  logic [31:0]  addr_b;
  logic [255:0] din_b, dout_b;

  dcache_line_memory #(.LINE_W(256), .DEPTH(512), .LATENCY(10), .ADDR_W(32)) dut_a (
    .clk_i(clk), .rst_i(rst), .enable_i(en_a), .write_i(wr_a), .addr_i(addr_a),
    .data_i(din_a), .ack_o(ack_a), .data_o(dout_a), .busy_o(busy_a));

  dcache_line_memory #(.LINE_W(256), .DEPTH(512), .LATENCY(1), .ADDR_W(32)) dut_b (
    .clk_i(clk), .rst_i(rst), .enable_i(en_b), .write_i(wr_b), .addr_i(addr_b),
    .data_i(din_b), .ack_o(ack_b), .data_o(dout_b), .busy_o(busy_b));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [255:0] data;
    int           cyc;
  } exp_t;

  exp_t         qa[$];
  exp_t         qb[$];
  exp_t         ea, eb;
  logic [255:0] model [512];
  bit           known [512];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // Monitors: every ack pops one expectation; outside acks data must be zero.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (ack_a) begin
        chk("a_ack_expected", 256'(qa.size() > 0), 256'(1));
        if (qa.size() > 0) begin
          ea = qa.pop_front();
          chk("a_ack_data", dout_a, ea.data);
          chk("a_ack_cycle", 256'(cyc), 256'(ea.cyc));
          chk("a_busy_in_ack", 256'(busy_a), 256'(1));
        end
      end else begin
        chk("a_data_zero_no_ack", dout_a, 256'(0));
      end
      if (ack_b) begin
        chk("b_ack_expected", 256'(qb.size() > 0), 256'(1));
        if (qb.size() > 0) begin
          eb = qb.pop_front();
          chk("b_ack_data", dout_b, eb.data);
          chk("b_ack_cycle", 256'(cyc), 256'(eb.cyc));
        end
      end else begin
        chk("b_data_zero_no_ack", dout_b, 256'(0));
      end
    end
  end

  task automatic req_a(input bit write, input logic [31:0] addr, input logic [255:0] data,
                       input bit disturb, input bit abort);
    int idx;
    int c;
    bit seen;
    idx  = int'((addr >> 5) & 32'd511);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (!busy_a) seen = 1'b1;
    end
    if (!seen) begin
      chk("a_idle_timeout", 256'(busy_a), 256'(0));
      return;
    end
    en_a = 1'b1; wr_a = write; addr_a = addr; din_a = data;
    c = cyc;
    qa.push_back('{data: (write ? 256'(0) : model[idx]), cyc: c + 1 + 10});
    @(posedge clk);
    #1 en_a = 1'b0;
    if (disturb) begin
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        en_a = ~en_a; wr_a = ~wr_a; addr_a = 32'h0000_00E0; din_a = 256'h1;
      end
      en_a = 1'b0;
    end
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (ack_a) seen = 1'b1;
    end
    if (!seen) chk("a_ack_timeout", 256'(ack_a), 256'(1));
    if (abort) begin
      #1 rst = 1'b1;
      #1;
      chk("rst_in_ack_ack", 256'(ack_a), 256'(0));
      chk("rst_in_ack_busy", 256'(busy_a), 256'(0));
      chk("rst_in_ack_data", dout_a, 256'(0));
      @(posedge clk);
      #1 rst = 1'b0;
    end else if (write) begin
      model[idx] = data;
      known[idx] = 1'b1;
    end
  endtask

  logic [255:0] pat;
  logic [31:0]  raddr;
  int           ridx, c0, nacks;
  bit           rwr;

  initial begin
    rst = 1'b1;
    en_a = 1'b0; wr_a = 1'b0; addr_a = '0; din_a = '0;
    en_b = 1'b0; wr_b = 1'b0; addr_b = '0; din_b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_ack", 256'({ack_a, ack_b}), 256'(0));
      chk("idle_busy", 256'({busy_a, busy_b}), 256'(0));
      chk("idle_data", dout_a | dout_b, 256'(0));
    end

    req_a(1'b1, 32'h0000_0040, {32{8'hA5}}, 1'b0, 1'b0);
    req_a(1'b0, 32'h0000_0040, '0, 1'b0, 1'b0);

    pat = rnd256();
    req_a(1'b1, 32'h0000_005F, pat, 1'b0, 1'b0);
    req_a(1'b0, 32'h0000_4040, '0, 1'b0, 1'b0);

    req_a(1'b1, 32'h0000_0060, rnd256(), 1'b0, 1'b0);
    req_a(1'b1, 32'h0000_00E0, rnd256(), 1'b0, 1'b0);
    req_a(1'b0, 32'h0000_0060, '0, 1'b1, 1'b0);
    req_a(1'b0, 32'h0000_00E0, '0, 1'b0, 1'b0);

    req_a(1'b1, 32'h0000_00A0, '0, 1'b0, 1'b0);
    req_a(1'b1, 32'h0000_00A0, {256{1'b1}}, 1'b0, 1'b1);
    req_a(1'b0, 32'h0000_00A0, '0, 1'b0, 1'b0);

    for (int n = 0; n < 20; n++) begin
      ridx  = $urandom_range(0, 15);
      raddr = ($urandom() & 32'hFFFF_C000) | 32'(ridx << 5) | 32'($urandom_range(0, 31));
      rwr   = !known[ridx] || ($urandom_range(0, 1) == 1);
      req_a(rwr, raddr, rnd256(), 1'b0, 1'b0);
    end

    pat = rnd256();
    @(negedge clk);
    c0 = cyc;
    en_b = 1'b1; wr_b = 1'b1; addr_b = 32'h0000_0000; din_b = pat;
    qb.push_back('{data: 256'(0), cyc: c0 + 2});
    for (int n = 1; n <= 5; n++) qb.push_back('{data: pat, cyc: c0 + 2 + 3 * n});
    @(posedge clk);
    #1 wr_b = 1'b0; din_b = '0;
    nacks = 0;
    for (int i = 0; i < 60 && nacks < 6; i++) begin
      @(negedge clk);
      if (ack_b) begin
        nacks++;
        if (nacks == 6) en_b = 1'b0;
      end
    end
    if (nacks < 6) chk("b_ack_timeout", 256'(nacks), 256'(6));

    repeat (10) @(negedge clk);
    chk("a_queue_drained", 256'(qa.size()), 256'(0));
    chk("b_queue_drained", 256'(qb.size()), 256'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
